sha256_msg_sched: RTL and testbench
===================================

// Module: sha256_msg_sched
// PURPOSE
//  SHA-256 message schedule stage, directly upstream of the SHA-256 round datapath.
//  Accepts the 16 32-bit words of a padded 512-bit block over a valid/ready stream.
//  Emits W0..W63 one word per transfer, each tagged with its round index.
//  With SHA256_KROM_EN it also emits the matching round constant Kj.
//  The round controller consumes each (Wj, Kj, idx) transfer to step the round logic once.
// PARAMETERS
//  WORDSIZE  32  datapath word width; only 32 is supported
//  ROUNDS    64  words emitted per block; must be in the range 17..64
// PORTS
//  clk        in   1   single clock; all state updates on the rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   in_word is valid
//  in_ready   out  1   stage accepts in_word this cycle
//  in_word    in   32  message word, big-endian order, M0 first
//  w_valid    out  1   w_word, k_word, w_idx and w_last are valid
//  w_ready    in   1   consumer accepts the current output
//  w_word     out  32  schedule word Wj
//  k_word     out  32  round constant K[j]; tied to 0 without SHA256_KROM_EN
//  w_idx      out  6   round index j
//  w_last     out  1   high when w_idx == ROUNDS-1
// BEHAVIOUR
//  Interface:
//  - One clock (clk); reset rst is synchronous and active-high.
//  - A transfer occurs when valid && ready on a rising edge.
//  Reset values:
//  - w_valid=0, w_word=0, k_word=0, w_idx=0, w_last=0.
//  - Window regs win[0..15]=0, counter cnt=0, state=LOAD.
//  Output register:
//  - The output is a single register slot; slot_free = !w_valid || w_ready.
//  - While w_valid && !w_ready, all outputs hold stable.
//  State LOAD (cnt < 16):
//  - in_ready = slot_free.
//  - On in transfer: w_word <= in_word; w_idx <= cnt; w_valid <= 1.
//  - Window shifts: win[i] <= win[i+1], win[15] <= in_word. Then cnt++.
//  - At cnt == 15 the next state is EXPAND.
//  - If slot_free && !in_valid: w_valid <= 0 (bubble).
//  - In and out transfers may occur in the same cycle: 1 word/clk, latency 1 clk.
//  State EXPAND (16 <= cnt < ROUNDS):
//  - in_ready = 0.
//  - When slot_free, each clk: Wt = s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32.
//  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//  - Load the output slot: w_word <= Wt, w_idx <= cnt, w_valid <= 1. Shift the window; cnt++.
//  - After loading cnt == ROUNDS-1, go to DRAIN.
//  State DRAIN:
//  - in_ready = 0; wait for the w_last transfer.
//  - On that transfer: cnt <= 0, state <= LOAD, w_valid <= 0.
//  - No overlap with the next block; a 1-clk gap is required.
//  Boundaries and exceptional cases:
//  - w_last = (w_idx == ROUNDS-1), registered together with w_word.
//  - rst mid-block: the partial block is discarded and all state returns to reset values.
//  - Words are never dropped or duplicated under any w_ready pattern.
//  - in_valid during EXPAND/DRAIN is ignored; the upstream holds its word.
// CONFIGURATION
//  SHA256_KROM_EN defined:
//  - 64x32 constant ROM, FIPS 180-4 K[0..63].
//  - k_word <= K[idx] is loaded in the same cycle as w_word, so Kj is aligned with Wj.
//  SHA256_KROM_EN undefined:
//  - No ROM; k_word is constant 0 and the round controller supplies Kj.
// TESTING
//  1 "abc" block:
//    - Stimulus: in = 61626380, 0 x14, 00000018.
//    - W0..W15 echo the inputs; W16 = 61626380; W17 = 000F0000; w_idx 0..63 in order.
//    - w_last is high only at idx 63.
//  2 Full throughput:
//    - Stimulus: in_valid and w_ready held high.
//    - 64 transfers in 64 consecutive clks after the first input.
//    - in_ready drops the clk after the 16th accept.
//  3 Backpressure:
//    - Stimulus: w_ready toggles pseudo-randomly across 3 back-to-back "abc" blocks.
//    - The output word sequence matches test 1 for each block.
//    - Outputs stay stable while stalled.
//  4 Reset mid-operation:
//    - Stimulus: rst at idx 30, then a new "abc" block.
//    - After reset, w_valid = 0 and in_ready = 1.
//    - The new block yields W16 = 61626380 (no stale window).
//  5 Input starvation:
//    - Stimulus: in_valid gaps during LOAD.
//    - w_valid drops during the gaps; indices stay contiguous with no duplicates.
//  6 SHA256_KROM_EN:
//    - idx 0 -> k_word 428A2F98; idx 63 -> k_word C67178F2.
//    - Without the macro, k_word = 0 throughout.

Source files
------------

// File: rtl/sha256_msg_sched_if.sv
// Stream bundle for the SHA-256 message schedule stage: message words in, (Wj, Kj, j) out.
interface sha256_msg_sched_if #(
  parameter int unsigned WORDSIZE = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] in_word;
  logic                w_valid;
  logic                w_ready;
  logic [WORDSIZE-1:0] w_word;
  logic [WORDSIZE-1:0] k_word;
  logic [5:0]          w_idx;
  logic                w_last;

  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, w_word, k_word, w_idx, w_last
  );

  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, w_word, k_word, w_idx, w_last
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads M0..M15, expands W16..W(ROUNDS-1) through a 16-word window.
// Optional macro SHA256_KROM_EN adds the K[j] constant ROM aligned with each Wj.
module sha256_msg_sched #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned ROUNDS   = 64
) (
  input logic              clk,
  input logic              rst,
  sha256_msg_sched_if.slave bus
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned IDX_W = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(15);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EXPAND = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [WORDSIZE-1:0] win [16];
  logic                w_valid_q;
  logic [WORDSIZE-1:0] w_word_q;
  logic [IDX_W-1:0]    w_idx_q;
  logic                w_last_q;

  logic                slot_free_c;
  logic                in_ready_c;
  logic                load_c;
  logic                clear_c;
  logic                restart_c;
  logic [WORDSIZE-1:0] next_word_c;
  logic [WORDSIZE-1:0] wt_c;

`ifdef SHA256_KROM_EN
  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [WORDSIZE-1:0] k_q;
`endif

  function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic logic [WORDSIZE-1:0] sig0(input logic [WORDSIZE-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORDSIZE-1:0] sig1(input logic [WORDSIZE-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win[0] is W[t-16], win[15] is W[t-1]
  assign wt_c        = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign slot_free_c = !w_valid_q || bus.w_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    load_c      = 1'b0;
    clear_c     = 1'b0;
    restart_c   = 1'b0;
    next_word_c = bus.in_word;
    case (state)
      LOAD: begin
        in_ready_c = slot_free_c;
        if (slot_free_c) begin
          if (bus.in_valid) begin
            load_c = 1'b1;
            if (cnt == LOAD_END) state_nxt = EXPAND;
          end else begin
            clear_c = 1'b1;
          end
        end
      end
      EXPAND: begin
        next_word_c = wt_c;
        if (slot_free_c) begin
          load_c = 1'b1;
          if (cnt == LAST_CNT) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Block ends once the consumer takes the w_last word
        if (w_valid_q && bus.w_ready) begin
          clear_c   = 1'b1;
          restart_c = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      w_valid_q <= 1'b0;
      w_word_q  <= '0;
      w_idx_q   <= '0;
      w_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
`ifdef SHA256_KROM_EN
      k_q       <= '0;
`endif
    end else if (load_c) begin
      w_valid_q <= 1'b1;
      w_word_q  <= next_word_c;
      w_idx_q   <= cnt[IDX_W-1:0];
      w_last_q  <= (cnt == LAST_CNT);
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15]   <= next_word_c;
      cnt       <= cnt + CNT_W'(1);
`ifdef SHA256_KROM_EN
      k_q       <= KROM[cnt[IDX_W-1:0]];
`endif
    end else if (clear_c) begin
      w_valid_q <= 1'b0;
      if (restart_c) cnt <= '0;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_word   = w_word_q;
  assign bus.w_idx    = w_idx_q;
  assign bus.w_last   = w_last_q;
`ifdef SHA256_KROM_EN
  assign bus.k_word   = k_q;
`else
  assign bus.k_word   = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: stimulus pushes expected (W, idx, last, K), a negedge monitor pops.
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_msg_sched_if #(.WORDSIZE(32)) bus ();

  sha256_msg_sched #(.WORDSIZE(32), .ROUNDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  idx;
    logic        last;
    logic        k_chk;
  } exp_t;

  exp_t        sb_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          xfer_total = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          rdy_rand = 1'b0;
  logic [31:0] msg  [16];
  logic [31:0] wexp [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: held high or pseudo-random
  initial bus.w_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.w_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stall stability plus in-order scoreboard pop on each transfer
  logic        stall_prev = 1'b0;
  logic [76:0] snap_prev;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if ({bus.w_valid, bus.w_word, bus.k_word, bus.w_idx, bus.w_last} !== snap_prev) begin
          n_fail++;
          $display("FAIL stall_hold: got %h expected %h",
                   {bus.w_valid, bus.w_word, bus.k_word, bus.w_idx, bus.w_last}, snap_prev);
        end
      end
      if (bus.w_valid && bus.w_ready) begin
        n_cmp++;
        xfer_total++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got idx %0d w %h, expected none", bus.w_idx, bus.w_word);
        end else begin
          e = sb_q.pop_front();
          if (bus.w_word !== e.w || bus.w_idx !== e.idx || bus.w_last !== e.last ||
              (e.k_chk && bus.k_word !== e.k)) begin
            n_fail++;
            $display("FAIL out_word: got idx %0d w %h last %b k %h, expected idx %0d w %h last %b k %h",
                     bus.w_idx, bus.w_word, bus.w_last, bus.k_word, e.idx, e.w, e.last, e.k);
          end
          if (bus.w_idx == 6'd0)  first_cyc = cyc;
          if (bus.w_idx == 6'd63) last_cyc  = cyc;
        end
      end
      stall_prev = bus.w_valid && !bus.w_ready;
      snap_prev  = {bus.w_valid, bus.w_word, bus.k_word, bus.w_idx, bus.w_last};
    end
  end

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  // Reference schedule in array form, W16/W17 of "abc" pinned to hand values
  task automatic push_block(input bit is_abc);
    exp_t e;
    for (int t = 0; t < 16; t++) wexp[t] = msg[t];
    for (int t = 16; t < 64; t++)
      wexp[t] = ssig1(wexp[t-2]) + wexp[t-7] + ssig0(wexp[t-15]) + wexp[t-16];
    if (is_abc) begin
      wexp[16] = 32'h61626380;
      wexp[17] = 32'h000f0000;
    end
    for (int t = 0; t < 64; t++) begin
      e.w    = wexp[t];
      e.idx  = 6'(t);
      e.last = (t == 63);
`ifdef SHA256_KROM_EN
      e.k_chk = (t == 0) || (t == 63);
      e.k     = (t == 0) ? 32'h428a2f98 : 32'hc67178f2;
`else
      e.k_chk = 1'b1;
      e.k     = 32'h0;
`endif
      sb_q.push_back(e);
    end
  endtask

  // Drive 16 words; optional 3-cycle starvation gap before word gap_at (ready held high)
  task automatic send_block(input bit is_abc, input int gap_at);
    int to;
    push_block(is_abc);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("gap_bubble_w_valid", 32'(bus.w_valid), 32'h0);
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_word  = msg[i];
      to = 0;
      @(negedge clk);
      while (!bus.in_ready && to < 500) begin
        @(negedge clk);
        to++;
      end
      if (to >= 500) check("in_ready_timeout", 32'(to), 32'h0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int to = 0;
    while (sb_q.size() != 0 && to < 3000) begin
      @(posedge clk);
      to++;
    end
    if (to >= 3000) check("drain_timeout_left", 32'(sb_q.size()), 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int to;
    bus.in_valid = 1'b0;
    bus.in_word  = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_w_valid",  32'(bus.w_valid), 32'h0);
    check("rst_w_word",   bus.w_word,       32'h0);
    check("rst_k_word",   bus.k_word,       32'h0);
    check("rst_w_idx",    32'(bus.w_idx),   32'h0);
    check("rst_w_last",   32'(bus.w_last),  32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;

    // "abc" at full throughput
    set_abc();
    send_block(1'b1, -1);
    @(negedge clk);
    check("in_ready_after_16", 32'(bus.in_ready), 32'h0);
    wait_drain();
    check("burst_span_cycles", 32'(last_cyc - first_cyc), 32'd63);

    // Three back-to-back "abc" blocks under random backpressure
    rdy_rand = 1'b1;
    for (int b = 0; b < 3; b++) send_block(1'b1, -1);
    wait_drain();

    // All-ones block, random backpressure (carry-heavy sums)
    for (int i = 0; i < 16; i++) msg[i] = 32'hffffffff;
    send_block(1'b0, -1);
    wait_drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Input starvation gap inside LOAD
    for (int i = 0; i < 16; i++) msg[i] = 32'h01020304 * 32'(i + 1);
    send_block(1'b0, 5);
    wait_drain();

    // Reset once idx 30 has been transferred, then a fresh "abc" block
    set_abc();
    base = xfer_total;
    send_block(1'b1, -1);
    to = 0;
    while (xfer_total - base < 31 && to < 500) begin
      @(negedge clk);
      to++;
    end
    if (to >= 500) check("idx30_timeout", 32'(to), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_w_valid",  32'(bus.w_valid),  32'h0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    send_block(1'b1, -1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
